btb_update_ctrl: RTL
====================

# btb_update_ctrl

Write-port sequencer for the FPGA (BRAM-based) branch target buffer. Accepts resolved-branch updates from the controller, buffers them in a 2-entry FIFO, and drives the BTB RAM write port one entry per cycle. Implements the row-by-row invalidation walk, at reset and on `flush_i`, that a single-cycle BRAM clear cannot do. Gates frontend prediction use via `predict_en_o` while the walk is in progress. Sits between the branch-resolution path and the per-lane BTB RAM instances in the frontend.

## Interface
- `NR_ROWS`, 4, BTB rows; power of two, ≥2; `ROW_W = $clog2(NR_ROWS)`
- `INSTR_PER_FETCH`, 2, lanes (one RAM per lane); `COL_W = max(1, $clog2(INSTR_PER_FETCH))`
- `TARGET_W`, 64, target address width (`riscv::VLEN`)
- `clk_i` in 1 — clock
- `rst_i` in 1 — reset, asynchronous, active-high
- `flush_i` in 1 — invalidate all BTB entries
- `debug_mode_i` in 1 — core in debug mode
- `upd_valid_i` in 1 — update request valid
- `upd_ready_o` out 1 — update accepted when valid && ready
- `upd_row_i` in ROW_W — row index of the branch PC
- `upd_col_i` in COL_W — lane index of the branch PC
- `upd_target_i` in TARGET_W — resolved target
- `ram_we_o` out INSTR_PER_FETCH — per-lane write enable
- `ram_addr_o` out ROW_W — write row, shared by all lanes
- `ram_wdata_o` out TARGET_W+1 — {valid, target}, shared by all lanes
- `predict_en_o` out 1 — BTB read data may be used
- `flush_busy_o` out 1 — invalidation walk in progress

## Operation
- FSM states: FLUSH, IDLE. Reset state is FLUSH with `flush_cnt = 0`. `flush_cnt` is ROW_W bits wide.
- FLUSH:
  - `ram_we_o` = all ones, `ram_addr_o = flush_cnt`, `ram_wdata_o = 0`.
  - `flush_cnt` increments each cycle.
  - When `flush_cnt == NR_ROWS-1`, go to IDLE and set `flush_cnt` to 0.
  - `flush_i` is ignored in FLUSH: no entry has been written since the walk started.
  - The FIFO is not drained in FLUSH; it keeps accepting updates while not full.
- IDLE:
  - If `flush_i` = 1: go to FLUSH, `flush_cnt = 0`, clear the FIFO. No RAM write this cycle.
  - Otherwise, if the FIFO is non-empty: pop the head and write it. `ram_we_o` is one-hot at `upd_col_i`, `ram_addr_o` = row, `ram_wdata_o = {1'b1, target}`.
  - Otherwise `ram_we_o = 0`.
- FIFO:
  - Depth 2, in-order. Push and pop may occur in the same cycle.
  - `upd_ready_o = !full && !flush_i`. Ready does not look ahead on a same-cycle pop.
- Accepted update with `debug_mode_i = 1`: the handshake completes but the entry is not pushed, i.e. it is dropped.
- Duplicate row/col entries are written in order, so the last write wins.
- `predict_en_o` = (state == IDLE) && !flush_i.
- `flush_busy_o` = (state == FLUSH).
- `ram_addr_o` and `ram_wdata_o` = 0 whenever `ram_we_o = 0`.

## Timing
- While `rst_i` is high, outputs are: `ram_we_o = 0`, `ram_addr_o = 0`, `ram_wdata_o = 0`, `upd_ready_o = 0`, `predict_en_o = 0`, `flush_busy_o = 1`.
- First walk write occurs in the first cycle after `rst_i` deasserts.
- Walk length is exactly NR_ROWS cycles. `predict_en_o` rises the cycle after the last walk write.
- Update latency: accepted at edge N → `ram_we_o` asserted in cycle N+1 (FIFO empty, IDLE). There is no combinational valid→we path.
- Throughput is one RAM write per cycle in IDLE.
- Outputs are combinational from state, `flush_cnt` and the FIFO head; all state is registered.
- `flush_i` in IDLE:
  - Same cycle: `predict_en_o` and `upd_ready_o` drop, and no RAM write.
  - Next cycle: walk row 0.
- Reset asserted mid-walk or with a non-empty FIFO: immediately returns to FLUSH with `flush_cnt = 0` and the FIFO empty. Updates in flight are lost.
- Updates accepted during FLUSH are written starting the cycle after entry to IDLE, in order.

## Test plan
- Reset release (NR_ROWS=4, IPF=2): `ram_we_o = 2'b11` with addr 0,1,2,3 on four consecutive cycles, wdata 0 → cycle 5: `predict_en_o = 1`, `flush_busy_o = 0`, `ram_we_o = 0`.
- Single update in IDLE: row 2, col 1, target 0x8000_0040 → next cycle `ram_we_o = 2'b10`, addr 2, wdata {1, 0x8000_0040}; idle after.
- Back-to-back: 3 updates offered on consecutive cycles → all accepted with no ready drop; writes follow on 3 consecutive cycles, in order.
- Backpressure during walk: 3 updates offered at reset release → first two accepted; `upd_ready_o = 0` for the third until the first is popped; all three written after the walk, in order.
- Flush with queued update: FIFO holds 1 entry, `flush_i` pulses in IDLE → no update write; 4-cycle walk; `predict_en_o` low for 5 cycles total.
- Debug drop: `debug_mode_i = 1` with update row 1, col 0 → `upd_ready_o = 1`, and `ram_we_o` stays 0 for the following cycles.

Source files
------------

// File: rtl/btb_update_ctrl.sv
// BTB write-port sequencer: queues resolved-branch updates in a 2-entry FIFO and
// drives the per-lane BTB RAM write port, walking every row to invalidate on reset/flush.
module btb_update_ctrl #(
    parameter  int unsigned NR_ROWS         = 4,
    parameter  int unsigned INSTR_PER_FETCH = 2,
    parameter  int unsigned TARGET_W        = 64,
    localparam int unsigned ROW_W           = $clog2(NR_ROWS),
    localparam int unsigned COL_W           = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic                       upd_valid_i,
    output logic                       upd_ready_o,
    input  logic [ROW_W-1:0]           upd_row_i,
    input  logic [COL_W-1:0]           upd_col_i,
    input  logic [TARGET_W-1:0]        upd_target_i,
    output logic [INSTR_PER_FETCH-1:0] ram_we_o,
    output logic [ROW_W-1:0]           ram_addr_o,
    output logic [TARGET_W:0]          ram_wdata_o,
    output logic                       predict_en_o,
    output logic                       flush_busy_o
);

    localparam int unsigned DEPTH = 2;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    typedef struct packed {
        logic [ROW_W-1:0]    row;
        logic [COL_W-1:0]    col;
        logic [TARGET_W-1:0] target;
    } upd_t;

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    flush_cnt_q, flush_cnt_d;
    upd_t                fifo_q [DEPTH];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;

    logic                fifo_full, fifo_empty;
    logic                push, pop, clear;
    logic                upd_ready_c;
    upd_t                upd_in, head;

    logic [INSTR_PER_FETCH-1:0] ram_we_c;
    logic [ROW_W-1:0]           ram_addr_c;
    logic [TARGET_W:0]          ram_wdata_c;

    assign fifo_full   = (count_q == 2'd2);
    assign fifo_empty  = (count_q == 2'd0);
    assign head        = fifo_q[rd_ptr_q];
    assign upd_in      = '{row: upd_row_i, col: upd_col_i, target: upd_target_i};
    // Ready ignores a same-cycle pop; debug-mode updates complete the handshake but are dropped.
    assign upd_ready_c = !fifo_full && !flush_i && !rst_i;
    assign push        = upd_valid_i && upd_ready_c && !debug_mode_i;

    // State register and FIFO pointers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage needs no reset: occupancy is tracked by count_q
    always_ff @(posedge clk_i) begin
        if (push && !clear) begin
            fifo_q[wr_ptr_q] <= upd_in;
        end
    end

    // Next state and RAM write port
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pop         = 1'b0;
        clear       = 1'b0;
        ram_we_c    = '0;
        ram_addr_c  = '0;
        ram_wdata_c = '0;
        case (state_q)
            ST_FLUSH: begin
                ram_we_c    = '1;
                ram_addr_c  = flush_cnt_q;
                flush_cnt_d = flush_cnt_q + ROW_W'(1);
                if (flush_cnt_q == ROW_W'(NR_ROWS - 1)) begin
                    state_d     = ST_IDLE;
                    flush_cnt_d = '0;
                end
            end
            ST_IDLE: begin
                if (flush_i) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                    clear       = 1'b1;
                end else if (!fifo_empty) begin
                    pop         = 1'b1;
                    ram_addr_c  = head.row;
                    ram_wdata_c = {1'b1, head.target};
                    for (int i = 0; i < int'(INSTR_PER_FETCH); i++) begin
                        ram_we_c[i] = (head.col == COL_W'(i));
                    end
                end
            end
            default: begin
                state_d = ST_FLUSH;
            end
        endcase
    end

    // FIFO pointer/occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Reset holds the write port quiet even though the state already reads FLUSH
    assign ram_we_o     = rst_i ? '0 : ram_we_c;
    assign ram_addr_o   = rst_i ? '0 : ram_addr_c;
    assign ram_wdata_o  = rst_i ? '0 : ram_wdata_c;
    assign upd_ready_o  = upd_ready_c;
    assign predict_en_o = (state_q == ST_IDLE) && !flush_i && !rst_i;
    assign flush_busy_o = (state_q == ST_FLUSH) || rst_i;

endmodule
